// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - one requester's req/gnt beat port onto the shared Data_Memory
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, we, addr, wdata, input gnt, rdata, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rdata, rvalid);
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - burst-limited GPP/comms-processor arbiter for the single-port Data_Memory
module data_memory_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int MAX_BURST    = 8,
    parameter int PRIORITY_GPP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_memory_arbiter_if.slave gpp,
    data_memory_arbiter_if.slave cp,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 owner
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_G, OWN_C} state_t;

    state_t            state;
    logic              gpp_gnt_q;
    logic              cp_gnt_q;
    logic              last_cp;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] gpp_rdata_q;
    logic [DATA_W-1:0] cp_rdata_q;
    logic              gpp_rvalid_q;
    logic              cp_rvalid_q;
    logic              beat_g;
    logic              beat_c;

    assign beat_g  = gpp_gnt_q & gpp.req;
    assign beat_c  = cp_gnt_q & cp.req;
    assign cnt_inc = (count == BURST_MAX) ? count : count + 1'b1;

    assign gpp.gnt    = gpp_gnt_q;
    assign gpp.rdata  = gpp_rdata_q;
    assign gpp.rvalid = gpp_rvalid_q;
    assign cp.gnt     = cp_gnt_q;
    assign cp.rdata   = cp_rdata_q;
    assign cp.rvalid  = cp_rvalid_q;

    // Memory bus follows the owner only on a beat; otherwise parked at zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (beat_g) begin
            mem_we    = gpp.we;
            mem_addr  = gpp.addr;
            mem_wdata = gpp.wdata;
        end else if (beat_c) begin
            mem_we    = cp.we;
            mem_addr  = cp.addr;
            mem_wdata = cp.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            gpp_gnt_q    <= 1'b0;
            cp_gnt_q     <= 1'b0;
            owner        <= 1'b0;
            last_cp      <= 1'b1;
            count        <= '0;
            gpp_rdata_q  <= '0;
            cp_rdata_q   <= '0;
            gpp_rvalid_q <= 1'b0;
            cp_rvalid_q  <= 1'b0;
        end else begin
            gpp_rvalid_q <= 1'b0;
            cp_rvalid_q  <= 1'b0;
            if (beat_g && !gpp.we) begin
                gpp_rdata_q  <= mem_rdata;
                gpp_rvalid_q <= 1'b1;
            end
            if (beat_c && !cp.we) begin
                cp_rdata_q  <= mem_rdata;
                cp_rvalid_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    count <= '0;
                    // Round-robin favours whoever did not own last; reset leaves CP as last.
                    if (gpp.req && (!cp.req || PRIORITY_GPP != 0 || last_cp)) begin
                        state     <= OWN_G;
                        gpp_gnt_q <= 1'b1;
                        owner     <= 1'b0;
                    end else if (cp.req) begin
                        state    <= OWN_C;
                        cp_gnt_q <= 1'b1;
                        owner    <= 1'b1;
                    end
                end
                OWN_G: begin
                    if (!gpp.req || (cp.req && cnt_inc == BURST_MAX)) begin
                        last_cp   <= 1'b0;
                        count     <= '0;
                        gpp_gnt_q <= 1'b0;
                        if (cp.req) begin
                            state    <= OWN_C;
                            cp_gnt_q <= 1'b1;
                            owner    <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= cnt_inc;
                    end
                end
                OWN_C: begin
                    if (!cp.req || (gpp.req && cnt_inc == BURST_MAX)) begin
                        last_cp  <= 1'b1;
                        count    <= '0;
                        cp_gnt_q <= 1'b0;
                        if (gpp.req) begin
                            state     <= OWN_G;
                            gpp_gnt_q <= 1'b1;
                            owner     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gpp_gnt_q <= 1'b0;
                    cp_gnt_q  <= 1'b0;
                    count     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - scoreboard bench for data_memory_arbiter over three parameterisations
module tb_data_memory_arbiter;
    localparam int NI = 3;
    localparam logic [1:0] GG = 2'b01;
    localparam logic [1:0] CC = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        g_req, g_we, c_req, c_we;
    logic [15:0] g_addr, g_wdata, c_addr, c_wdata;
    logic [NI-1:0] gg, cg, grv, crv, mwe, own;
    logic [15:0] grd [NI];
    logic [15:0] crd [NI];
    logic [15:0] maddr [NI];
    logic [15:0] mwd [NI];
    logic [15:0] mrd [NI];
    logic [15:0] mem0 [256];

    int checks = 0;
    int failures = 0;
    logic [1:0]  exp_q [$];
    logic [15:0] gq [$];
    logic [15:0] cq [$];

    always #5 clk = ~clk;

    // inst0: fixed priority, burst 8; inst1: round-robin, burst 8; inst2: fixed priority, burst 1
    genvar k;
    generate
        for (k = 0; k < NI; k++) begin : g_inst
            data_memory_arbiter_if gi ();
            data_memory_arbiter_if ci ();
            assign gi.req   = g_req;
            assign gi.we    = g_we;
            assign gi.addr  = g_addr;
            assign gi.wdata = g_wdata;
            assign ci.req   = c_req;
            assign ci.we    = c_we;
            assign ci.addr  = c_addr;
            assign ci.wdata = c_wdata;
            assign gg[k]  = gi.gnt;
            assign cg[k]  = ci.gnt;
            assign grv[k] = gi.rvalid;
            assign crv[k] = ci.rvalid;
            assign grd[k] = gi.rdata;
            assign crd[k] = ci.rdata;
            assign mrd[k] = (k == 0) ? mem0[maddr[k][7:0]] : (maddr[k] ^ 16'hA5A5);

            data_memory_arbiter #(
                .DATA_W(16), .ADDR_W(16),
                .MAX_BURST(k == 2 ? 1 : 8),
                .PRIORITY_GPP(k == 1 ? 0 : 1)
            ) dut (
                .clk(clk), .rst(rst),
                .gpp(gi), .cp(ci),
                .mem_we(mwe[k]), .mem_addr(maddr[k]), .mem_wdata(mwd[k]),
                .mem_rdata(mrd[k]), .owner(own[k])
            );
        end
    endgenerate

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 16'(i * 37 + 5);
        end else if (mwe[0]) begin
            mem0[maddr[0][7:0]] <= mwd[0];
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        g_req = 1'b0;
        c_req = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        g_req = 0; g_we = 0; g_addr = '0; g_wdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({cg[i], gg[i]} !== 2'b00) begin
                failures++; $display("FAIL reset_gnt inst%0d got=%b exp=00", i, {cg[i], gg[i]});
            end
            checks++;
            if ({grv[i], crv[i], mwe[i], own[i]} !== 4'b0000) begin
                failures++; $display("FAIL reset_flags inst%0d got=%b exp=0000", i, {grv[i], crv[i], mwe[i], own[i]});
            end
            checks++;
            if ({maddr[i], mwd[i], grd[i], crd[i]} !== 64'h0) begin
                failures++; $display("FAIL reset_bus inst%0d got=%h exp=0", i, {maddr[i], mwd[i], grd[i], crd[i]});
            end
        end
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_write_read;
        logic [15:0] e;
        g_req = 1; g_we = 1; g_addr = 16'h0010; g_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({gg[0], mwe[0]} !== 2'b00) begin
            failures++; $display("FAIL pre_grant got=%b exp=00", {gg[0], mwe[0]});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cg[0], gg[0], mwe[0]} !== 3'b011 || maddr[0] !== 16'h0010 || mwd[0] !== 16'hBEEF) begin
            failures++; $display("FAIL write_beat got=%b addr=%h data=%h exp=011 0010 beef",
                                 {cg[0], gg[0], mwe[0]}, maddr[0], mwd[0]);
        end
        next_cycle();
        g_we = 0;
        gq.push_back(16'hBEEF);
        @(negedge clk);
        checks++;
        if ({grv[0], mwe[0]} !== 2'b00) begin
            failures++; $display("FAIL read_beat_cycle got=%b exp=00", {grv[0], mwe[0]});
        end
        next_cycle();
        g_req = 0;
        @(negedge clk);
        checks++;
        if (grv[0] !== 1'b1 || gq.size() == 0) begin
            failures++; $display("FAIL read_rvalid got=%b exp=1", grv[0]);
        end else begin
            e = gq.pop_front();
            checks++;
            if (grd[0] !== e) begin
                failures++; $display("FAIL read_data got=%h exp=%h", grd[0], e);
            end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({grv[0], gg[0]} !== 2'b00) begin
            failures++; $display("FAIL read_release got=%b exp=00", {grv[0], gg[0]});
        end
        gq.delete();
        go_idle();
    endtask

    task automatic test_burst_fixed;
        logic [1:0]  e;
        logic [15:0] d;
        gq.delete(); cq.delete(); exp_q.delete();
        repeat (8) exp_q.push_back(GG);
        repeat (8) exp_q.push_back(CC);
        repeat (8) exp_q.push_back(GG);
        g_req = 1; g_we = 0; g_addr = 16'h0040;
        c_req = 1; c_we = 0; c_addr = 16'h0060;
        next_cycle();
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (grv[0]) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++; $display("FAIL burst_g_rvalid cycle%0d got=1 exp=0", i);
                end else begin
                    d = gq.pop_front();
                    if (grd[0] !== d) begin
                        failures++; $display("FAIL burst_g_rdata cycle%0d got=%h exp=%h", i, grd[0], d);
                    end
                end
            end
            if (crv[0]) begin
                checks++;
                if (cq.size() == 0) begin
                    failures++; $display("FAIL burst_c_rvalid cycle%0d got=1 exp=0", i);
                end else begin
                    d = cq.pop_front();
                    if (crd[0] !== d) begin
                        failures++; $display("FAIL burst_c_rdata cycle%0d got=%h exp=%h", i, crd[0], d);
                    end
                end
            end
            if (i <= 24) begin
                e = exp_q.pop_front();
                checks++;
                if ({cg[0], gg[0]} !== e) begin
                    failures++; $display("FAIL burst_gnt cycle%0d got=%b exp=%b", i, {cg[0], gg[0]}, e);
                end
                checks++;
                if (own[0] !== e[1]) begin
                    failures++; $display("FAIL burst_owner cycle%0d got=%b exp=%b", i, own[0], e[1]);
                end
                if (e == GG) gq.push_back(mem0[g_addr[7:0]]);
                else         cq.push_back(mem0[c_addr[7:0]]);
                next_cycle();
                g_addr = g_addr + 1'b1;
                c_addr = c_addr + 1'b1;
                if (i == 24) begin
                    g_req = 0; c_req = 0;
                end
            end
        end
        checks++;
        if (gq.size() != 0 || cq.size() != 0) begin
            failures++; $display("FAIL burst_rvalid_missing got=%0d,%0d exp=0,0", gq.size(), cq.size());
        end
        go_idle();
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        rst = 1'b0;
        go_idle();
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(GG); exp_q.push_back(CC); exp_q.push_back(GG); exp_q.push_back(CC);
        for (int r = 0; r < 4; r++) begin
            g_req = 1; c_req = 1; g_we = 0; c_we = 0;
            next_cycle();
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({cg[1], gg[1]} !== e) begin
                failures++; $display("FAIL rr_gnt round%0d got=%b exp=%b", r, {cg[1], gg[1]}, e);
            end
            checks++;
            if ({cg[0], gg[0]} !== GG) begin
                failures++; $display("FAIL fixed_gnt round%0d got=%b exp=%b", r, {cg[0], gg[0]}, GG);
            end
            next_cycle();
            g_req = 0; c_req = 0;
            next_cycle();
        end
        go_idle();
    endtask

    task automatic test_drop_handover;
        logic [1:0] e;
        exp_q.delete();
        repeat (5) exp_q.push_back(CC);
        repeat (8) exp_q.push_back(GG);
        exp_q.push_back(CC);
        c_req = 1; c_we = 1; c_addr = 16'h0080; c_wdata = 16'h1234;
        g_we = 0; g_addr = 16'h0050;
        next_cycle();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({cg[0], gg[0]} !== e) begin
                failures++; $display("FAIL drop_gnt cycle%0d got=%b exp=%b", i, {cg[0], gg[0]}, e);
            end
            if (i == 5) begin
                checks++;
                if (mwe[0] !== 1'b0) begin
                    failures++; $display("FAIL drop_mem_we got=%b exp=0", mwe[0]);
                end
            end
            next_cycle();
            if (i == 2) g_req = 1;
            if (i == 4) c_req = 0;
            if (i == 5) c_req = 1;
            c_addr  = c_addr + 1'b1;
            c_wdata = c_wdata + 1'b1;
        end
        go_idle();
    endtask

    task automatic test_burst_one;
        logic [1:0] e;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? GG : CC);
        repeat (20) exp_q.push_back(GG);
        g_req = 1; c_req = 1; g_we = 0; c_we = 0;
        next_cycle();
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({cg[2], gg[2]} !== e) begin
                failures++; $display("FAIL mb1_gnt cycle%0d got=%b exp=%b", i, {cg[2], gg[2]}, e);
            end
            next_cycle();
            if (i == 6) c_req = 0;
        end
        go_idle();
    endtask

    task automatic test_reset_mid_burst;
        c_req = 1; c_we = 1; c_addr = 16'h0090; c_wdata = 16'hCAFE;
        next_cycle();
        next_cycle();
        c_we = 0;
        next_cycle();
        c_we = 1;
        @(negedge clk);
        checks++;
        if ({cg[0], mwe[0], crv[0]} !== 3'b111) begin
            failures++; $display("FAIL pre_reset_state got=%b exp=111", {cg[0], mwe[0], crv[0]});
        end
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({cg[i], gg[i], mwe[i], crv[i], grv[i]} !== 5'b00000) begin
                failures++; $display("FAIL async_reset inst%0d got=%b exp=00000", i, {cg[i], gg[i], mwe[i], crv[i], grv[i]});
            end
        end
        c_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        g_req = 1; g_we = 0; g_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (gg[0] !== 1'b0) begin
            failures++; $display("FAIL post_reset_early got=%b exp=0", gg[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({cg[0], gg[0]} !== GG) begin
            failures++; $display("FAIL post_reset_gnt got=%b exp=%b", {cg[0], gg[0]}, GG);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_fixed();
        test_round_robin();
        test_drop_handover();
        test_burst_one();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
